// File: rtl/vx_dcr_arbiter.sv
// vx_dcr_arbiter: round-robin arbiter sharing the DCR write bus between requesters.
// Each grant issues one registered write strobe and is followed by MIN_GAP idle cycles.
module vx_dcr_arbiter #(
    parameter int NUM_REQS   = 2,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int MIN_GAP    = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQS-1:0]            req_valid,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQS-1:0]            req_ready,
    output logic                           dcr_write_valid,
    output logic [ADDR_WIDTH-1:0]          dcr_write_addr,
    output logic [DATA_WIDTH-1:0]          dcr_write_data,
    output logic                           busy
);
    localparam int PW = NUM_REQS > 1 ? $clog2(NUM_REQS) : 1;
    localparam int GW = MIN_GAP > 0 ? $clog2(MIN_GAP + 1) : 1;
    logic [PW-1:0]           r_rr_ptr;
    logic [GW-1:0]           r_gap_cnt;
    logic                    r_wv;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [2*NUM_REQS-1:0]   w_rot;
    logic                    w_found;
    logic                    w_accept;
    logic [PW-1:0]           w_sel;
    int                      w_off;
    // Rotating the doubled request vector puts the round-robin pointer at bit 0.
    assign w_rot = {req_valid, req_valid} >> r_rr_ptr;
    always_comb begin
        w_found = 1'b0;
        w_off   = 0;
        for (int j = NUM_REQS - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_found = 1'b1;
                w_off   = j;
            end
        end
        w_sel = PW'((int'(r_rr_ptr) + w_off) % NUM_REQS);
    end
    assign w_accept        = reset && w_found && (r_gap_cnt == '0);
    assign req_ready       = w_accept ? (NUM_REQS'(1) << w_sel) : '0;
    assign dcr_write_valid = r_wv;
    assign dcr_write_addr  = r_addr;
    assign dcr_write_data  = r_data;
    assign busy            = r_wv || (r_gap_cnt != '0);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr  <= '0;
            r_gap_cnt <= '0;
            r_wv      <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
        end else if (w_accept) begin
            r_rr_ptr  <= PW'((int'(w_sel) + 1) % NUM_REQS);
            r_gap_cnt <= GW'(MIN_GAP);
            r_wv      <= 1'b1;
            r_addr    <= req_addr[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
            r_data    <= req_data[w_sel*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            r_wv <= 1'b0;
            if (r_gap_cnt != '0)
                r_gap_cnt <= r_gap_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_vx_dcr_arbiter.sv
// tb_vx_dcr_arbiter: two arbiters (MIN_GAP=2 and MIN_GAP=0) on shared stimulus,
// checked by vector tables, directed sequences and a cycle-level reference model.
module tb_vx_dcr_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  v = '0;
    logic [23:0] ra = '0;
    logic [63:0] rd = '0;
    logic [1:0]  rdy [2];
    logic        wv  [2];
    logic [11:0] wa  [2];
    logic [31:0] wd  [2];
    logic        bsy [2];
    int n_pass = 0;
    int n_tot  = 0;
    int          m_ptr  [2];
    int          m_cool [2];
    logic        m_wv   [2];
    logic [11:0] m_wa   [2];
    logic [31:0] m_wd   [2];
    int          gap    [2] = '{2, 0};

    typedef struct {
        logic [1:0] v;
        logic [1:0] rdy;
        logic       wv;
        logic       busy;
    } vec_t;
    vec_t tbl[$];

    vx_dcr_arbiter #(.NUM_REQS(2), .ADDR_WIDTH(12), .DATA_WIDTH(32), .MIN_GAP(2)) u0 (
        .clk(clk), .reset(reset), .req_valid(v), .req_addr(ra), .req_data(rd),
        .req_ready(rdy[0]), .dcr_write_valid(wv[0]), .dcr_write_addr(wa[0]),
        .dcr_write_data(wd[0]), .busy(bsy[0]));
    vx_dcr_arbiter #(.NUM_REQS(2), .ADDR_WIDTH(12), .DATA_WIDTH(32), .MIN_GAP(0)) u1 (
        .clk(clk), .reset(reset), .req_valid(v), .req_addr(ra), .req_data(rd),
        .req_ready(rdy[1]), .dcr_write_valid(wv[1]), .dcr_write_addr(wa[1]),
        .dcr_write_data(wd[1]), .busy(bsy[1]));

    always #5 clk = ~clk;

    function automatic int exp_grant(int d);
        if (!reset || m_cool[d] != 0) return -1;
        for (int j = 0; j < 2; j++)
            if (v[(m_ptr[d] + j) % 2]) return (m_ptr[d] + j) % 2;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0; m_cool[d] = 0; m_wv[d] = 1'b0; m_wa[d] = '0; m_wd[d] = '0;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            int g = exp_grant(d);
            chk($sformatf("m%0d_ready", d), rdy[d], g < 0 ? 2'b00 : 2'(1 << g));
            chk($sformatf("m%0d_wvalid", d), wv[d], m_wv[d]);
            chk($sformatf("m%0d_busy", d), bsy[d], m_wv[d] || m_cool[d] > 0);
            if (m_wv[d]) begin
                chk($sformatf("m%0d_addr", d), wa[d], m_wa[d]);
                chk($sformatf("m%0d_data", d), wd[d], m_wd[d]);
            end
        end
    endtask

    // Inputs are set at posedge+1; outputs sampled later, model advanced at the edge.
    task automatic cycle();
        #3;
        check_all();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            int g = exp_grant(d);
            if (g >= 0) begin
                m_wv[d] = 1'b1; m_wa[d] = ra[g*12 +: 12]; m_wd[d] = rd[g*32 +: 32];
                m_ptr[d] = (g + 1) % 2; m_cool[d] = gap[d];
            end else begin
                m_wv[d] = 1'b0;
                if (m_cool[d] > 0) m_cool[d]--;
            end
        end
        #1;
    endtask

    initial begin
        // single write from req0 then req1, so contention starts with the pointer at 0
        tbl.push_back('{2'b01, 2'b01, 1'b0, 1'b0});
        tbl.push_back('{2'b00, 2'b00, 1'b1, 1'b1});
        tbl.push_back('{2'b00, 2'b00, 1'b0, 1'b1});
        tbl.push_back('{2'b00, 2'b00, 1'b0, 1'b0});
        tbl.push_back('{2'b10, 2'b10, 1'b0, 1'b0});
        tbl.push_back('{2'b00, 2'b00, 1'b1, 1'b1});
        tbl.push_back('{2'b00, 2'b00, 1'b0, 1'b1});
        tbl.push_back('{2'b00, 2'b00, 1'b0, 1'b0});
        for (int r = 0; r < 4; r++) begin
            tbl.push_back('{2'b11, (r % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 1'b0});
            tbl.push_back('{(r == 3) ? 2'b00 : 2'b11, 2'b00, 1'b1, 1'b1});
            tbl.push_back('{(r == 3) ? 2'b00 : 2'b11, 2'b00, 1'b0, 1'b1});
        end
        tbl.push_back('{2'b00, 2'b00, 1'b0, 1'b0});
        // withdrawn request during the gap
        tbl.push_back('{2'b10, 2'b10, 1'b0, 1'b0});
        tbl.push_back('{2'b01, 2'b00, 1'b1, 1'b1});
        tbl.push_back('{2'b00, 2'b00, 1'b0, 1'b1});
        tbl.push_back('{2'b10, 2'b10, 1'b0, 1'b0});
        tbl.push_back('{2'b00, 2'b00, 1'b1, 1'b1});
        tbl.push_back('{2'b00, 2'b00, 1'b0, 1'b1});
        tbl.push_back('{2'b00, 2'b00, 1'b0, 1'b0});

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_addr", wa[0], 12'h0);
        chk("rst_data", wd[0], 32'h0);
        reset = 1'b1;

        ra = {12'h0A5, 12'h001};
        rd = {32'h1234_5678, 32'h8000_0000};
        foreach (tbl[i]) begin
            v = tbl[i].v;
            #3;
            chk($sformatf("tbl%0d_ready", i), rdy[0], tbl[i].rdy);
            chk($sformatf("tbl%0d_wvalid", i), wv[0], tbl[i].wv);
            chk($sformatf("tbl%0d_busy", i), bsy[0], tbl[i].busy);
            if (i == 1) begin
                chk("tbl_single_addr", wa[0], 12'h001);
                chk("tbl_single_data", wd[0], 32'h8000_0000);
            end
            cycle();
        end

        for (int i = 0; i < 4; i++) begin
            rd[63:32] = 32'hD000_0000 + 32'(i);
            v = 2'b10;
            #2;
            chk("nogap_ready", rdy[1], 2'b10);
            cycle();
            #1;
            chk("nogap_wvalid", wv[1], 1'b1);
            chk("nogap_data", wd[1], 32'hD000_0000 + 32'(i));
        end
        v = 2'b00;
        repeat (3) cycle();

        v = 2'b01;
        cycle();
        v = 2'b00;
        cycle();
        v = 2'b11;
        reset = 1'b0;
        model_reset();
        #1;
        chk("midgap_wvalid", wv[0], 1'b0);
        chk("midgap_busy", bsy[0], 1'b0);
        chk("midgap_ready", rdy[0], 2'b00);
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        chk("post_rst_ready", rdy[0], 2'b01);
        cycle();
        v = 2'b00;
        repeat (3) cycle();

        v = 2'b01;
        cycle();
        v = 2'b00;
        repeat (100) cycle();
        v = 2'b11;
        #2;
        chk("idle_ptr_ready", rdy[0], 2'b10);
        cycle();
        v = 2'b00;
        repeat (3) cycle();

        repeat (400) begin
            v = 2'($urandom);
            ra = 24'($urandom);
            rd = {$urandom, $urandom};
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b0;
                model_reset();
                #1;
                check_all();
                @(posedge clk);
                #1;
                reset = 1'b1;
            end else begin
                cycle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/vx_dcr_arbiter.md
# VX_dcr_arbiter

Round-robin arbiter that shares the single device-configuration-register (DCR) write bus between multiple requesters, such as the host interface and the on-chip debug/boot sequencer. Each accepted write is registered and driven onto the DCR bus as a one-cycle `write_valid` pulse. A programmable minimum gap is enforced between consecutive writes so that pipelined DCR fan-out to clusters and cores can settle. The block sits in front of the DCR bus slaves that latch base DCRs: startup address/argument and MPM class.

## Interface
Parameters:
- `NUM_REQS`, default 2: number of requesters, ≥1.
- `ADDR_WIDTH`, default `VX_DCR_ADDR_WIDTH` (12): DCR address width.
- `DATA_WIDTH`, default `VX_DCR_DATA_WIDTH` (32): DCR data width.
- `MIN_GAP`, default 2: idle cycles forced after each issued write, ≥0.

Ports:
- `clk`, in, 1: clock; all state is updated on its rising edge.
- `reset`, in, 1: asynchronous, active-low (asserted at 0). Clears all state immediately.
- `req_valid`, in, `NUM_REQS`: per-requester write request.
- `req_addr`, in, `NUM_REQS*ADDR_WIDTH`: requester i occupies slice `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_data`, in, `NUM_REQS*DATA_WIDTH`: requester i occupies slice `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready`, out, `NUM_REQS`: one-hot grant. Combinational from `req_valid` and state.
- `dcr_write_valid`, out, 1: registered write strobe to the DCR bus master side.
- `dcr_write_addr`, out, `ADDR_WIDTH`: registered address.
- `dcr_write_data`, out, `DATA_WIDTH`: registered data.
- `busy`, out, 1: high while `dcr_write_valid` is high or the gap counter is non-zero.

## Operation
- State consists of:
  - `rr_ptr`: `$clog2(NUM_REQS)` bits; width 1 when `NUM_REQS==1`.
  - `gap_cnt`: `$clog2(MIN_GAP+1)` bits; width 1 minimum.
  - The output registers.
- Two states, derived from `gap_cnt`:
  - **ISSUE** (`gap_cnt==0`): arbitration is enabled.
  - **GAP** (`gap_cnt!=0`): all `req_ready` are 0, and `gap_cnt` decrements by 1 per cycle.
- Arbitration in ISSUE:
  - The grant goes to the first i with `req_valid[i]=1`, searching `rr_ptr`, `rr_ptr+1`, … modulo `NUM_REQS`.
  - `req_ready[i]=1` only for the granted i, and only when `req_valid[i]=1`.
  - With no valid requests, `req_ready` is all 0 and no state changes.
- On an accepted request (`req_valid[i] & req_ready[i]` at edge k):
  - `dcr_write_valid`, `dcr_write_addr` and `dcr_write_data` are loaded from requester i and appear after edge k.
  - `rr_ptr` becomes (i+1) mod `NUM_REQS`.
  - `gap_cnt` is loaded with `MIN_GAP`.
- `dcr_write_valid` is high for exactly one cycle per accepted request; it clears at the next edge. The DCR bus has no backpressure.
- `dcr_write_addr` and `dcr_write_data` hold their last values when `dcr_write_valid` is 0. Verification must not check them when `dcr_write_valid` is 0.
- Requesters hold `req_valid`, `req_addr` and `req_data` stable until they see `req_ready`.
  - Deasserting `req_valid` without a grant is legal; the request is simply not considered.
  - The arbiter never buffers more than one write.
- With `MIN_GAP==0`, `gap_cnt` stays 0 and grants may occur every cycle, one per cycle, rotating among active requesters.
- With `NUM_REQS==1`, `rr_ptr` stays 0.
- Reset (`reset==0`) at any time, including mid-gap or with `dcr_write_valid` high, has the following effect:
  - `dcr_write_valid`=0, `dcr_write_addr`=0, `dcr_write_data`=0, `gap_cnt`=0, `rr_ptr`=0.
  - `req_ready`=0 while reset is asserted.
  - An in-flight write is dropped, not replayed.
- No address decoding: every address is forwarded unchanged. Slaves ignore addresses they do not own.

## Timing
- Grant-to-strobe latency is 1 cycle: a request accepted at edge k drives `dcr_write_valid` high in cycle k..k+1.
- Minimum spacing between consecutive grants is `MIN_GAP+1` cycles. With `MIN_GAP=2`, grants can occur at edges k, k+3, k+6, …
- `busy` rises in the cycle after an accept. With `MIN_GAP>0`, it falls after `gap_cnt` returns to 0.
- `req_ready` has a combinational path from `req_valid`. There is no path from `req_ready` back to `req_valid`, so no combinational loops.
- The first arbitration after reset release can occur at the first rising edge with `reset==1`.

## Test plan
- **Single write:** after reset, req0 writes addr=0x001, data=0x8000_0000.
  - Required: `req_ready[0]`=1 for one cycle.
  - Next cycle: `dcr_write_valid`=1, addr=0x001, data=0x8000_0000.
  - Then `busy` is high for 2 further cycles.
- **Contention:** req0 and req1 both valid and held, with `MIN_GAP=2`.
  - Required grant order: 0, 1, 0, 1.
  - Grants occur at edges k, k+3, k+6, k+9.
  - Each grant is followed by exactly one `dcr_write_valid` pulse carrying the matching addr/data.
- **No-gap back-to-back:** `MIN_GAP=0`, req1 holding 4 distinct writes.
  - Required: 4 consecutive `dcr_write_valid` cycles with data in order.
  - `rr_ptr` wraps correctly.
- **Withdrawn request:** req0 asserts `req_valid` during GAP, then deasserts before `gap_cnt` reaches 0.
  - Required: no grant and no strobe.
  - req1, valid at `gap_cnt`=0, is granted.
- **Reset mid-gap:** assert `reset=0` one cycle after an accept.
  - Required: `dcr_write_valid`=0 immediately (asynchronous); `busy`=0; `req_ready`=0.
  - After release, the first grant goes to req0 even if req1 was next.
- **Idle:** `req_valid`=0 for 100 cycles.
  - Required: no strobe, `busy`=0, `rr_ptr` unchanged.
